// File: rtl/div_issue_ctrl.sv
// ----------------------------------------------------------------------------
// div_issue_ctrl
//   EX-stage controller in front of the multi-cycle divider. It accepts a
//   DIV/DIVU from EX, latches the operands, drives the divider start/annul
//   handshake, stalls the pipeline while the divide is in flight, and returns
//   {HI=remainder, LO=quotient} as a one-cycle HI/LO write. It also handles
//   flush, divide-by-zero and divider timeout.
//
// Ports
//   clk            : rising-edge clock
//   rst            : asynchronous reset, active low
//   op_valid_i     : EX holds a divide op this cycle
//   op_signed_i    : 1 = DIV (signed), 0 = DIVU
//   op_a_i/op_b_i  : dividend / divisor from EX
//   flush_i        : pipeline flush, kills the current op
//   div_result_i   : divider result {remainder, quotient}
//   div_ready_i    : divider result valid (registered on the divider side)
//   div_start_o    : divider start, held high until the result is taken
//   div_annul_o    : divider abort pulse
//   div_signed_o   : latched signedness
//   div_opdata1_o  : latched dividend, stable for the whole op
//   div_opdata2_o  : latched divisor, stable for the whole op
//   stallreq_o     : stall request to pipeline control (combinational)
//   whilo_o        : HI/LO write enable, one-cycle pulse
//   hi_o / lo_o    : remainder / quotient
//   dbz_o          : high with whilo_o when the divisor was zero
//   err_o          : one-cycle pulse on timeout abort
//   state_dbg_o    : current FSM state (0 IDLE, 1 WAIT, 2 DONE, 3 RECOVER)
//
// Handshake with the divider: div_start_o acts as "request valid" and stays
// high for the whole of WAIT; the divider answers with div_ready_i, which the
// controller consumes in the cycle it is seen (moving to DONE, where
// div_start_o drops so the divider is released). div_annul_o withdraws the
// request in the same cycle div_start_o falls because of flush or timeout.
// ----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic        op_signed_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        dbz_o,
    output logic        err_o,
    output logic [1:0]  state_dbg_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(RECOVER_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DONE    = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            signed_q;
    logic [31:0]     opa_q, opb_q;
    logic            dbz_q;
    logic [31:0]     hi_q, lo_q;

    // Event decode. Inside WAIT the priority is flush, then ready, then timeout.
    logic issue, in_wait, wait_flush, wait_done, wait_tmo, rec_last;

    assign issue      = (state_q == S_IDLE) && op_valid_i && !flush_i;
    assign in_wait    = (state_q == S_WAIT);
    assign wait_flush = in_wait && flush_i;
    assign wait_done  = in_wait && !flush_i && div_ready_i;
    assign wait_tmo   = in_wait && !flush_i && !div_ready_i
                        && (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign rec_last   = (rcnt_q == RW'(RECOVER_CYC - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        // Counters restart from zero whenever their state is entered.
        cnt_d   = in_wait ? cnt_q + CW'(1) : '0;
        rcnt_d  = (state_q == S_RECOVER) ? rcnt_q + RW'(1) : '0;
        unique case (state_q)
            S_IDLE: begin
                if (issue) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_flush || wait_tmo) state_d = S_RECOVER;
                else if (wait_done)         state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_RECOVER: begin
                if (rec_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- operand / result datapath ----------------
    // Operands are sampled only on issue; EX may change op_*_i during WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signed_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (issue) begin
                signed_q <= op_signed_i;
                opa_q    <= op_a_i;
                opb_q    <= op_b_i;
                dbz_q    <= (op_b_i == 32'd0);
            end
            if (wait_done) begin
                // A zero divisor always writes (0,0), whatever the divider returns.
                hi_q <= dbz_q ? 32'd0 : div_result_i[63:32];
                lo_q <= dbz_q ? 32'd0 : div_result_i[31:0];
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        div_start_o = in_wait && !wait_flush && !wait_tmo;
        div_annul_o = wait_flush || wait_tmo;
        err_o       = wait_tmo;
        whilo_o     = (state_q == S_DONE) && !flush_i;
        dbz_o       = (state_q == S_DONE) && !flush_i && dbz_q;
        // Low in DONE so the pipeline advances together with the HI/LO write.
        stallreq_o  = issue || in_wait || ((state_q == S_RECOVER) && op_valid_i);
    end

    assign div_signed_o  = signed_q;
    assign div_opdata1_o = opa_q;
    assign div_opdata2_o = opb_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid_i = 1'b0;
  logic        op_signed_i = 1'b0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        stallreq_o, whilo_o, dbz_o, err_o;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  state_dbg_o;

  int checks = 0;
  int errors = 0;

  // stub divider controls
  bit stub_en = 1'b1;
  int stub_lat = 5;
  int stub_cnt;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_signed_i(op_signed_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .stallreq_o(stallreq_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .dbz_o(dbz_o), .err_o(err_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stub divider ----------------
  function automatic logic [63:0] stub_calc(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    logic na, nb;
    if (b == 32'd0) return 64'd0;
    na = s & a[31];
    nb = s & b[31];
    ua = na ? -a : a;
    ub = nb ? -b : b;
    q = ua / ub;
    r = ua % ub;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_cnt     <= 0;
      div_ready_i  <= 1'b0;
      div_result_i <= 64'd0;
    end else if (!div_start_o) begin
      stub_cnt    <= 0;
      div_ready_i <= 1'b0;
    end else if (stub_en && !div_ready_i) begin
      if (stub_cnt == stub_lat) begin
        div_ready_i  <= 1'b1;
        div_result_i <= stub_calc(div_signed_o, div_opdata1_o, div_opdata2_o);
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic do_op(input string name, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_lo,
                       input logic [31:0] exp_hi, input logic exp_dbz, input bit last);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    op_valid_i = 1'b1; op_signed_i = s; op_a_i = a; op_b_i = b;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++; $display("FAIL %s issue_stall: got %b expected 1", name, stallreq_o);
    end
    @(negedge clk);
    checks++;
    if (div_start_o !== 1'b1 || div_opdata1_o !== a || div_opdata2_o !== b
        || div_signed_o !== s) begin
      errors++;
      $display("FAIL %s latch: start=%b a=%h b=%h s=%b expected 1 %h %h %b",
               name, div_start_o, div_opdata1_o, div_opdata2_o, div_signed_o, a, b, s);
    end
    // EX is free to change its operands while stalled
    op_a_i = ~a; op_b_i = ~b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (whilo_o === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s whilo_timeout: got 0 expected 1 within 100 cycles", name);
    end else begin
      checks++;
      if (lo_o !== exp_lo) begin
        errors++; $display("FAIL %s lo: got %h expected %h", name, lo_o, exp_lo);
      end
      checks++;
      if (hi_o !== exp_hi) begin
        errors++; $display("FAIL %s hi: got %h expected %h", name, hi_o, exp_hi);
      end
      checks++;
      if (dbz_o !== exp_dbz) begin
        errors++; $display("FAIL %s dbz: got %b expected %b", name, dbz_o, exp_dbz);
      end
      checks++;
      if (stallreq_o !== 1'b0 || err_o !== 1'b0 || div_start_o !== 1'b0) begin
        errors++;
        $display("FAIL %s done_cycle: stall=%b err=%b start=%b expected 0 0 0",
                 name, stallreq_o, err_o, div_start_o);
      end
    end
    if (last) begin
      op_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: whilo=%b stall=%b expected 0 0", name, whilo_o, stallreq_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg_o !== 2'd0 || div_start_o !== 1'b0 || div_annul_o !== 1'b0
        || whilo_o !== 1'b0 || err_o !== 1'b0 || dbz_o !== 1'b0 || stallreq_o !== 1'b0
        || hi_o !== 32'd0 || lo_o !== 32'd0 || div_opdata1_o !== 32'd0
        || div_opdata2_o !== 32'd0 || div_signed_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: st=%0d start=%b annul=%b whilo=%b hi=%h lo=%h a=%h b=%h expected all 0",
               state_dbg_o, div_start_o, div_annul_o, whilo_o, hi_o, lo_o,
               div_opdata1_o, div_opdata2_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 1'b1);
    do_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1);
    do_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_div_by_zero();
    do_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    op_valid_i = 1'b1; op_signed_i = 1'b0; op_a_i = 32'd8; op_b_i = 32'd2; flush_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall: got %b expected 0", stallreq_o);
    end
    @(negedge clk);
    checks++;
    if (state_dbg_o !== 2'd0 || div_start_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_noissue: st=%0d start=%b expected 0 0", state_dbg_o, div_start_o);
    end
    flush_i = 1'b0; op_valid_i = 1'b0;
  endtask

  task automatic test_flush_wait();
    stub_lat = 40;
    @(negedge clk);
    op_valid_i = 1'b1; op_signed_i = 1'b0; op_a_i = 32'd1000; op_b_i = 32'd3;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++;
    if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || whilo_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_annul: annul=%b start=%b whilo=%b err=%b expected 1 0 0 0",
               div_annul_o, div_start_o, whilo_o, err_o);
    end
    @(negedge clk);
    flush_i = 1'b0; op_valid_i = 1'b0;
    #1;
    checks++;
    if (div_annul_o !== 1'b0 || div_start_o !== 1'b0 || stallreq_o !== 1'b0
        || state_dbg_o !== 2'd3) begin
      errors++;
      $display("FAIL flush_recover1: annul=%b start=%b stall=%b st=%0d expected 0 0 0 3",
               div_annul_o, div_start_o, stallreq_o, state_dbg_o);
    end
    @(negedge clk);
    op_valid_i = 1'b1;
    #1;
    checks++;
    if (div_start_o !== 1'b0 || stallreq_o !== 1'b1 || state_dbg_o !== 2'd3 || whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_recover2: start=%b stall=%b st=%0d whilo=%b expected 0 1 3 0",
               div_start_o, stallreq_o, state_dbg_o, whilo_o);
    end
    stub_lat = 5;
    do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b0);
    do_op("b2b_21_4", 1'b0, 32'd21, 32'd4, 32'd5, 32'd1, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    int err_at;
    err_at = -1;
    stub_en = 1'b0;
    @(negedge clk);
    op_valid_i = 1'b1; op_signed_i = 1'b0; op_a_i = 32'd77; op_b_i = 32'd7;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (err_o === 1'b1) begin err_at = i; break; end
    end
    checks++;
    if (err_at != 64) begin
      errors++; $display("FAIL timeout_cycle: got %0d expected 64", err_at);
    end
    checks++;
    if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_annul: annul=%b start=%b whilo=%b expected 1 0 0",
               div_annul_o, div_start_o, whilo_o);
    end
    op_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || div_annul_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: err=%b annul=%b stall=%b expected 0 0 0",
               err_o, div_annul_o, stallreq_o);
    end
    stub_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit saw_whilo;
    saw_whilo = 1'b0;
    stub_lat = 40;
    @(negedge clk);
    op_valid_i = 1'b1; op_signed_i = 1'b0; op_a_i = 32'd50; op_b_i = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b0; op_valid_i = 1'b0;
    #1;
    checks++;
    if (div_start_o !== 1'b0 || state_dbg_o !== 2'd0 || div_opdata1_o !== 32'd0
        || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: start=%b st=%0d a=%h stall=%b expected 0 0 0 0",
               div_start_o, state_dbg_o, div_opdata1_o, stallreq_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (whilo_o === 1'b1) saw_whilo = 1'b1;
    end
    checks++;
    if (saw_whilo) begin
      errors++; $display("FAIL reset_mid_op_whilo: got 1 expected 0");
    end
    stub_lat = 5;
    do_op("post_reset_divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 1'b1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_flush_idle();
    test_flush_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
